// File: rtl/div_32_16.sv
// 32/16 restoring divider, one quotient bit per clock, fixed 33-cycle latency.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module div_32_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_start,
   input  logic [31:0] div_a,
   input  logic [15:0] div_b,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] div_quo,
   output logic [15:0] div_rem,
   output logic        div_dz,
   output logic        div_ovf
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] quo_q;
   logic [16:0] rem_q;
   logic [15:0] dvs_q;
   logic [15:0] alo_q;
   logic        dz_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] res_quo_q;
   logic [15:0] res_rem_q;
   logic        res_dz_q;

   logic [31:0] a_mag_d;
   logic [15:0] b_mag_d;
   logic [17:0] trial_d;
   logic        take_d;
   logic [16:0] rem_d;
   logic [31:0] fquo_d;
   logic [15:0] frem_d;

`ifdef DIV_SIGNED_EN
   logic sa_q, sb_q, ovf_q, res_ovf_q;
   logic ovf_acc_d;

   always_comb begin
      a_mag_d   = div_a[31] ? (~div_a + 32'd1) : div_a;
      b_mag_d   = div_b[15] ? (~div_b + 16'd1) : div_b;
      ovf_acc_d = (div_a == 32'h8000_0000) && (div_b == 16'hFFFF);
   end
`else
   always_comb begin
      a_mag_d = div_a;
      b_mag_d = div_b;
   end
`endif

   // 18-bit trial keeps the full 17-bit partial remainder visible to the compare
   always_comb begin
      trial_d = {rem_q, quo_q[31]};
      take_d  = (trial_d >= {2'b00, dvs_q});
      rem_d   = take_d ? (trial_d[16:0] - {1'b0, dvs_q}) : trial_d[16:0];
      fquo_d  = quo_q;
      frem_d  = rem_q[15:0];
`ifdef DIV_SIGNED_EN
      if (sa_q ^ sb_q) fquo_d = ~quo_q + 32'd1;
      if (sa_q)        frem_d = ~rem_q[15:0] + 16'd1;
`endif
      if (dz_q) begin
         fquo_d = '1;
         frem_d = alo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         alo_q     <= '0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         res_quo_q <= '0;
         res_rem_q <= '0;
         res_dz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         ovf_q     <= 1'b0;
         res_ovf_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (div_start) begin
                  state_q <= CALC;
                  cnt_q   <= '0;
                  quo_q   <= a_mag_d;
                  rem_q   <= '0;
                  dvs_q   <= b_mag_d;
                  alo_q   <= div_a[15:0];
                  dz_q    <= (div_b == 16'h0000);
                  busy_q  <= 1'b1;
`ifdef DIV_SIGNED_EN
                  sa_q    <= div_a[31];
                  sb_q    <= div_b[15];
                  ovf_q   <= ovf_acc_d;
`endif
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= {quo_q[30:0], take_d};
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= FIX;
            end
            FIX: begin
               res_quo_q <= fquo_d;
               res_rem_q <= frem_d;
               res_dz_q  <= dz_q;
`ifdef DIV_SIGNED_EN
               res_ovf_q <= ovf_q;
`endif
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign div_busy = busy_q;
   assign div_done = done_q;
   assign div_quo  = res_quo_q;
   assign div_rem  = res_rem_q;
   assign div_dz   = res_dz_q;
`ifdef DIV_SIGNED_EN
   assign div_ovf  = res_ovf_q;
`else
   assign div_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_div_32_16.sv
// Directed self-checking bench for div_32_16; expectations follow DIV_SIGNED_EN.
module tb_div_32_16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_start = 1'b0;
   logic [31:0] div_a = '0;
   logic [15:0] div_b = '0;
   logic        div_busy, div_done, div_dz, div_ovf;
   logic [31:0] div_quo;
   logic [15:0] div_rem;

   int n_chk = 0;
   int n_fail = 0;
   int lat, bn, k, dseen;

   div_32_16 dut (
      .clk       (clk),
      .rst       (rst),
      .div_start (div_start),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_busy  (div_busy),
      .div_done  (div_done),
      .div_quo   (div_quo),
      .div_rem   (div_rem),
      .div_dz    (div_dz),
      .div_ovf   (div_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Accepts at the next rising edge; lat counts cycles from accept to done.
   task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int inj,
                         output int l, output int busy_n);
      @(negedge clk);
      div_start = 1'b1; div_a = a; div_b = b;
      @(negedge clk);
      div_start = 1'b0; div_a = ~a; div_b = ~b;
      l = 0; busy_n = 0;
      while (!div_done && l < 60) begin
         if (div_busy) busy_n++;
         if (l == inj) begin
            div_start = 1'b1; div_a = 32'd5; div_b = 16'd5;
         end else div_start = 1'b0;
         @(negedge clk);
         l++;
      end
      div_start = 1'b0;
   endtask

   task automatic check_res(input string tag, input int l, input int busy_n,
                            input logic [31:0] q, input logic [15:0] r,
                            input logic dz, input logic ov, input bit pulse);
      chk({tag, "_lat"},  l, 33);
      chk({tag, "_busy"}, busy_n, 33);
      chk({tag, "_quo"},  div_quo, q);
      chk({tag, "_rem"},  {16'h0, div_rem}, {16'h0, r});
      chk({tag, "_dz"},   {31'h0, div_dz}, {31'h0, dz});
      chk({tag, "_ovf"},  {31'h0, div_ovf}, {31'h0, ov});
      if (pulse) begin
         @(negedge clk);
         chk({tag, "_done1"}, {31'h0, div_done}, 32'h0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, div_busy}, 32'h0);
      chk("rst_done", {31'h0, div_done}, 32'h0);
      chk("rst_quo",  div_quo, 32'h0);
      chk("rst_rem",  {16'h0, div_rem}, 32'h0);
      chk("rst_dz",   {31'h0, div_dz}, 32'h0);
      chk("rst_ovf",  {31'h0, div_ovf}, 32'h0);
      rst = 1'b0;

      run_op(32'd100, 16'd7, -1, lat, bn);
      check_res("basic", lat, bn, 32'd14, 16'd2, 1'b0, 1'b0, 1'b1);

      run_op(32'd1000, 16'd3, 10, lat, bn);
      check_res("ignstart", lat, bn, 32'd333, 16'd1, 1'b0, 1'b0, 1'b1);

      run_op(32'h1234_5678, 16'h0000, -1, lat, bn);
      check_res("divzero", lat, bn, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0, 1'b1);

      // Abort mid-calculation; start asserted alongside rst must lose
      @(negedge clk);
      div_start = 1'b1; div_a = 32'd500; div_b = 16'd10;
      @(negedge clk);
      div_start = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_busy_pre", {31'h0, div_busy}, 32'h1);
      chk("abort_hold_quo", div_quo, 32'hFFFF_FFFF);
      chk("abort_hold_dz",  {31'h0, div_dz}, 32'h1);
      rst = 1'b1; div_start = 1'b1; div_a = 32'd9; div_b = 16'd2;
      @(negedge clk);
      chk("abort_busy", {31'h0, div_busy}, 32'h0);
      chk("abort_done", {31'h0, div_done}, 32'h0);
      chk("abort_quo",  div_quo, 32'h0);
      chk("abort_rem",  {16'h0, div_rem}, 32'h0);
      chk("abort_dz",   {31'h0, div_dz}, 32'h0);
      chk("abort_ovf",  {31'h0, div_ovf}, 32'h0);
      rst = 1'b0; div_start = 1'b0;
      dseen = 0;
      repeat (40) begin
         @(negedge clk);
         if (div_done || div_busy) dseen++;
      end
      chk("abort_nodone", dseen, 0);

`ifdef DIV_SIGNED_EN
      run_op(32'hFFFF_FF9C, 16'd7, -1, lat, bn);
      check_res("negdvd", lat, bn, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run_op(32'd100, 16'hFFF9, -1, lat, bn);
      check_res("negdvs", lat, bn, 32'hFFFF_FFF2, 16'd2, 1'b0, 1'b0, 1'b0);
      run_op(32'h8000_0000, 16'hFFFF, -1, lat, bn);
      check_res("ovf", lat, bn, 32'h8000_0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      run_op(32'hFFFF_FFFF, 16'hFFFF, -1, lat, bn);
      check_res("allones", lat, bn, 32'h0000_0001, 16'h0000, 1'b0, 1'b0, 1'b0);
      run_op(32'h1234_5678, 16'h8000, -1, lat, bn);
      check_res("dvs8000", lat, bn, 32'hFFFF_DB98, 16'h5678, 1'b0, 1'b0, 1'b0);
`else
      run_op(32'hFFFF_FF9C, 16'd7, -1, lat, bn);
      check_res("negdvd", lat, bn, 32'h2492_4916, 16'd2, 1'b0, 1'b0, 1'b0);
      run_op(32'd100, 16'hFFF9, -1, lat, bn);
      check_res("negdvs", lat, bn, 32'h0000_0000, 16'h0064, 1'b0, 1'b0, 1'b0);
      run_op(32'h8000_0000, 16'hFFFF, -1, lat, bn);
      check_res("ovf", lat, bn, 32'h0000_8000, 16'h8000, 1'b0, 1'b0, 1'b1);
      run_op(32'hFFFF_FFFF, 16'hFFFF, -1, lat, bn);
      check_res("allones", lat, bn, 32'h0001_0001, 16'h0000, 1'b0, 1'b0, 1'b0);
      run_op(32'h1234_5678, 16'h8000, -1, lat, bn);
      check_res("dvs8000", lat, bn, 32'h0000_2468, 16'h5678, 1'b0, 1'b0, 1'b0);
`endif

      // Back-to-back: second start presented in the done cycle of the first
      run_op(32'd77, 16'd5, -1, lat, bn);
      check_res("b2b_first", lat, bn, 32'd15, 16'd2, 1'b0, 1'b0, 1'b0);
      div_start = 1'b1; div_a = 32'd1000; div_b = 16'd7;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) div_start = 1'b0;
      end while (!div_done && k < 80);
      chk("b2b_gap", k, 34);
      chk("b2b_quo", div_quo, 32'd142);
      chk("b2b_rem", {16'h0, div_rem}, 32'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
